// File: rtl/inst_prog_loader.sv
// -----------------------------------------------------------------------------
// inst_prog_loader
//
// Streams a program into instruction memory through the core's instruction
// write port. A load request latches a base address and a word count; the
// block then issues one address-setup cycle, accepts the requested number of
// words over a valid/ready stream, and finishes with a one-cycle PC-reset and
// completion pulse. Zero-length requests complete immediately; requests that
// would run past the end of instruction memory are rejected with err_o.
//
// Optional feature (macro INST_PROG_LOADER_AUTOSTART_EN):
//   When defined, completion also pulses core_start_o and the block stays busy
//   in a RUN state until core_enable_i has been seen high and then low.
//   When undefined, core_start_o is tied low and core_enable_i is unused.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   clr_i                synchronous clear, highest priority
//   load_start_i         single-cycle load request (honoured only when idle)
//   cfg_base_addr_i      first instruction address
//   cfg_len_i            number of words to load
//   data_i/data_valid_i  instruction stream in
//   data_ready_o         stream ready (high throughout the LOAD state)
//   inst_wr_*_o          instruction-memory write control
//   inst_pc_reset_o      PC reset strobe issued on completion
//   core_start_o         core start pulse (autostart build only)
//   core_enable_i        core running status (autostart build only)
//   busy_o, done_o, err_o  status: not idle, completion pulse, rejection pulse
// -----------------------------------------------------------------------------
module inst_prog_loader #(
    parameter int RegAddrWidth = 32,
    parameter int InstMemDepth = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clr_i,
    input  logic                    load_start_i,
    input  logic [RegAddrWidth-1:0] cfg_base_addr_i,
    input  logic [RegAddrWidth-1:0] cfg_len_i,
    input  logic [RegAddrWidth-1:0] data_i,
    input  logic                    data_valid_i,
    output logic                    data_ready_o,
    output logic                    inst_wr_mode_o,
    output logic [RegAddrWidth-1:0] inst_wr_addr_o,
    output logic                    inst_wr_addr_en_o,
    output logic [RegAddrWidth-1:0] inst_wr_data_o,
    output logic                    inst_wr_data_en_o,
    output logic                    inst_pc_reset_o,
    output logic                    core_start_o,
    input  logic                    core_enable_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        LOAD   = 3'd2,
        FINISH = 3'd3
`ifdef INST_PROG_LOADER_AUTOSTART_EN
        ,
        RUN    = 3'd4
`endif
    } state_e;

    localparam logic [RegAddrWidth-1:0] ZERO_W = {RegAddrWidth{1'b0}};
    localparam logic [RegAddrWidth:0]   DEPTH_X = (RegAddrWidth+1)'(InstMemDepth);

    state_e                  state_q, state_d;
    logic [RegAddrWidth-1:0] cnt_q, cnt_d;
    logic [RegAddrWidth-1:0] base_q, base_d;
    logic [RegAddrWidth-1:0] len_q, len_d;

    logic                    wr_mode_q, wr_mode_d;
    logic                    addr_en_q, addr_en_d;
    logic [RegAddrWidth-1:0] addr_q, addr_d;
    logic                    ready_q, ready_d;
    logic                    pc_reset_q, pc_reset_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    core_start_q, core_start_d;

    logic                    zero_done_s;
    logic                    reject_s;
    logic [RegAddrWidth:0]   end_addr_s;

`ifdef INST_PROG_LOADER_AUTOSTART_EN
    logic                    seen_en_q, seen_en_d;
`else
    logic                    unused_core_enable_s;
    assign unused_core_enable_s = core_enable_i;
`endif

    // One extra bit so base+len cannot wrap before the depth comparison.
    assign end_addr_s = {1'b0, cfg_base_addr_i} + {1'b0, cfg_len_i};

    // Next-state, counter and latched-config logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        len_d       = len_q;
        zero_done_s = 1'b0;
        reject_s    = 1'b0;
`ifdef INST_PROG_LOADER_AUTOSTART_EN
        seen_en_d   = seen_en_q;
`endif
        if (clr_i) begin
            state_d = IDLE;
            cnt_d   = ZERO_W;
            base_d  = ZERO_W;
            len_d   = ZERO_W;
`ifdef INST_PROG_LOADER_AUTOSTART_EN
            seen_en_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_start_i) begin
                        base_d = cfg_base_addr_i;
                        len_d  = cfg_len_i;
                        cnt_d  = ZERO_W;
                        if (cfg_len_i == ZERO_W) begin
                            zero_done_s = 1'b1;
                        end else if (end_addr_s > DEPTH_X) begin
                            reject_s = 1'b1;
                        end else begin
                            state_d = ADDR;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                ADDR: begin
                    state_d = LOAD;
                end
                LOAD: begin
                    // ready is always high in LOAD, so valid alone is the handshake.
                    if (data_valid_i) begin
                        cnt_d = cnt_q + {{(RegAddrWidth-1){1'b0}}, 1'b1};
                        if (cnt_q == len_q - {{(RegAddrWidth-1){1'b0}}, 1'b1}) begin
                            state_d = FINISH;
                        end else begin
                            state_d = LOAD;
                        end
                    end else begin
                        state_d = LOAD;
                    end
                end
                FINISH: begin
`ifdef INST_PROG_LOADER_AUTOSTART_EN
                    state_d   = RUN;
                    seen_en_d = 1'b0;
`else
                    state_d = IDLE;
`endif
                end
`ifdef INST_PROG_LOADER_AUTOSTART_EN
                RUN: begin
                    // Return to idle only after a full high-then-low core run.
                    if (core_enable_i) begin
                        seen_en_d = 1'b1;
                    end else if (seen_en_q) begin
                        state_d   = IDLE;
                        seen_en_d = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so every status/strobe output is a flop.
    always_comb begin
        wr_mode_d    = (state_d == ADDR) || (state_d == LOAD);
        addr_en_d    = (state_d == ADDR);
        addr_d       = (state_d == ADDR) ? base_d : ZERO_W;
        ready_d      = (state_d == LOAD);
        pc_reset_d   = (state_d == FINISH);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FINISH) || zero_done_s;
        err_d        = reject_s;
`ifdef INST_PROG_LOADER_AUTOSTART_EN
        core_start_d = (state_d == FINISH);
`else
        core_start_d = 1'b0;
`endif
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= ZERO_W;
            base_q       <= ZERO_W;
            len_q        <= ZERO_W;
            wr_mode_q    <= 1'b0;
            addr_en_q    <= 1'b0;
            addr_q       <= ZERO_W;
            ready_q      <= 1'b0;
            pc_reset_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_start_q <= 1'b0;
`ifdef INST_PROG_LOADER_AUTOSTART_EN
            seen_en_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            len_q        <= len_d;
            wr_mode_q    <= wr_mode_d;
            addr_en_q    <= addr_en_d;
            addr_q       <= addr_d;
            ready_q      <= ready_d;
            pc_reset_q   <= pc_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_start_q <= core_start_d;
`ifdef INST_PROG_LOADER_AUTOSTART_EN
            seen_en_q    <= seen_en_d;
`endif
        end
    end

    assign data_ready_o      = ready_q;
    assign inst_wr_mode_o    = wr_mode_q;
    assign inst_wr_addr_en_o = addr_en_q;
    assign inst_wr_addr_o    = addr_q;
    // Write data path is a combinational pass-through while loading.
    assign inst_wr_data_en_o = ready_q & data_valid_i;
    assign inst_wr_data_o    = ready_q ? data_i : ZERO_W;
    assign inst_pc_reset_o   = pc_reset_q;
    assign core_start_o      = core_start_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_inst_prog_loader.sv
// -----------------------------------------------------------------------------
// Table-driven bench for inst_prog_loader. Each record is one clock cycle:
// inputs are driven on the falling edge and all outputs are compared 1 time
// unit later. Flags are packed as
//   {busy, wr_mode, addr_en, data_en, ready, pc_reset, done, err, core_start}.
// -----------------------------------------------------------------------------
module tb_inst_prog_loader;

    localparam int W = 32;

    typedef struct {
        string       name;
        logic        start;
        logic        clr;
        logic        en;
        logic        valid;
        logic [W-1:0] base;
        logic [W-1:0] len;
        logic [W-1:0] data;
        logic [8:0]   flags;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
    } vec_t;

    localparam logic [8:0] F_IDLE  = 9'b000000000;
    localparam logic [8:0] F_ADDR  = 9'b111000000;
    localparam logic [8:0] F_LOAD  = 9'b110010000;
    localparam logic [8:0] F_LOADD = 9'b110110000;
    localparam logic [8:0] F_FIN   = 9'b100001100;
    localparam logic [8:0] F_FINCS = 9'b100001101;
    localparam logic [8:0] F_RUN   = 9'b100000000;
    localparam logic [8:0] F_DONE  = 9'b000000100;
    localparam logic [8:0] F_ERR   = 9'b000000010;

    localparam logic [W-1:0] Z  = 32'h0;
    localparam logic [W-1:0] WA = 32'hA0A0_0001;
    localparam logic [W-1:0] WB = 32'hB0B0_0002;
    localparam logic [W-1:0] WC = 32'hC0C0_0003;
    localparam logic [W-1:0] WD = 32'hD0D0_0004;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         clr_i, load_start_i, data_valid_i, core_enable_i;
    logic [W-1:0] cfg_base_addr_i, cfg_len_i, data_i;
    logic         data_ready_o, inst_wr_mode_o, inst_wr_addr_en_o, inst_wr_data_en_o;
    logic         inst_pc_reset_o, core_start_o, busy_o, done_o, err_o;
    logic [W-1:0] inst_wr_addr_o, inst_wr_data_o;

    int nvec = 0;
    int nerr = 0;
    vec_t vq[$];

    inst_prog_loader dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clr_i            (clr_i),
        .load_start_i     (load_start_i),
        .cfg_base_addr_i  (cfg_base_addr_i),
        .cfg_len_i        (cfg_len_i),
        .data_i           (data_i),
        .data_valid_i     (data_valid_i),
        .data_ready_o     (data_ready_o),
        .inst_wr_mode_o   (inst_wr_mode_o),
        .inst_wr_addr_o   (inst_wr_addr_o),
        .inst_wr_addr_en_o(inst_wr_addr_en_o),
        .inst_wr_data_o   (inst_wr_data_o),
        .inst_wr_data_en_o(inst_wr_data_en_o),
        .inst_pc_reset_o  (inst_pc_reset_o),
        .core_start_o     (core_start_o),
        .core_enable_i    (core_enable_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic add(input string name, input logic start, input logic clr,
                       input logic en, input logic valid, input logic [W-1:0] base,
                       input logic [W-1:0] len, input logic [W-1:0] data,
                       input logic [8:0] flags, input logic [W-1:0] addr,
                       input logic [W-1:0] wdata);
        vec_t v;
        v.name = name; v.start = start; v.clr = clr; v.en = en; v.valid = valid;
        v.base = base; v.len = len; v.data = data;
        v.flags = flags; v.addr = addr; v.wdata = wdata;
        vq.push_back(v);
    endtask

    task automatic compare(input string name, input logic [8:0] flags,
                           input logic [W-1:0] addr, input logic [W-1:0] wdata);
        logic [8:0] act;
        act = {busy_o, inst_wr_mode_o, inst_wr_addr_en_o, inst_wr_data_en_o,
               data_ready_o, inst_pc_reset_o, done_o, err_o, core_start_o};
        nvec++;
        if (act !== flags || inst_wr_addr_o !== addr || inst_wr_data_o !== wdata) begin
            nerr++;
            $display("FAIL %s: got flags=%b addr=%h wdata=%h, want flags=%b addr=%h wdata=%h",
                     name, act, inst_wr_addr_o, inst_wr_data_o, flags, addr, wdata);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk_i);
        load_start_i    = v.start;
        clr_i           = v.clr;
        core_enable_i   = v.en;
        data_valid_i    = v.valid;
        cfg_base_addr_i = v.base;
        cfg_len_i       = v.len;
        data_i          = v.data;
        #1;
        compare(v.name, v.flags, v.addr, v.wdata);
    endtask

    initial begin
        rst_ni = 1'b0;
        clr_i = 1'b0; load_start_i = 1'b0; data_valid_i = 1'b0; core_enable_i = 1'b0;
        cfg_base_addr_i = Z; cfg_len_i = Z; data_i = Z;

        repeat (2) @(negedge clk_i);
        #1;
        compare("in_reset", F_IDLE, Z, Z);
        @(negedge clk_i);
        rst_ni = 1'b1;

        //   name          st  clr en  vld base         len    data  flags    addr   wdata
        add("reset_idle",  0,  0,  0,  0,  Z,           Z,     Z,    F_IDLE,  Z,     Z);
`ifndef INST_PROG_LOADER_AUTOSTART_EN
        // Back-to-back 3-word load at base 4; a stray start in LOAD is ignored.
        add("b2b_start",   1,  0,  0,  0,  32'd4,       32'd3, Z,    F_IDLE,  Z,     Z);
        add("b2b_addr",    0,  0,  0,  0,  Z,           Z,     Z,    F_ADDR,  32'd4, Z);
        add("b2b_wA",      0,  0,  0,  1,  Z,           Z,     WA,   F_LOADD, Z,     WA);
        add("b2b_wB_ign",  1,  0,  0,  1,  32'd50,      32'd9, WB,   F_LOADD, Z,     WB);
        add("b2b_wC",      0,  0,  0,  1,  Z,           Z,     WC,   F_LOADD, Z,     WC);
        add("b2b_finish",  0,  0,  0,  0,  Z,           Z,     Z,    F_FIN,   Z,     Z);
        add("b2b_idle",    0,  0,  0,  0,  Z,           Z,     Z,    F_IDLE,  Z,     Z);
        // 3-word load with a 5-cycle valid gap after the first word.
        add("gap_start",   1,  0,  0,  0,  32'd0,       32'd3, Z,    F_IDLE,  Z,     Z);
        add("gap_addr",    0,  0,  0,  0,  Z,           Z,     Z,    F_ADDR,  Z,     Z);
        add("gap_w1",      0,  0,  0,  1,  Z,           Z,     WA,   F_LOADD, Z,     WA);
        for (int i = 0; i < 5; i++)
            add("gap_stall", 0, 0,  0,  0,  Z,           Z,     Z,    F_LOAD,  Z,     Z);
        add("gap_w2",      0,  0,  0,  1,  Z,           Z,     WB,   F_LOADD, Z,     WB);
        add("gap_w3",      0,  0,  0,  1,  Z,           Z,     WC,   F_LOADD, Z,     WC);
        add("gap_finish",  0,  0,  0,  0,  Z,           Z,     Z,    F_FIN,   Z,     Z);
        add("gap_idle",    0,  0,  0,  0,  Z,           Z,     Z,    F_IDLE,  Z,     Z);
        // Out-of-range request: 126+3 > 128.
        add("oor_start",   1,  0,  0,  0,  32'd126,     32'd3, Z,    F_IDLE,  Z,     Z);
        add("oor_err",     0,  0,  0,  1,  Z,           Z,     WA,   F_ERR,   Z,     Z);
        add("oor_idle",    0,  0,  0,  0,  Z,           Z,     Z,    F_IDLE,  Z,     Z);
        // base+len wraps at 32 bits; must still be rejected.
        add("wrap_start",  1,  0,  0,  0,  32'hFFFF_FFFF, 32'd2, Z,  F_IDLE,  Z,     Z);
        add("wrap_err",    0,  0,  0,  0,  Z,           Z,     Z,    F_ERR,   Z,     Z);
        // Exactly at the top of memory: 125+3 == 128 is accepted.
        add("edge_start",  1,  0,  0,  0,  32'd125,     32'd3, Z,    F_IDLE,  Z,     Z);
        add("edge_addr",   0,  0,  0,  0,  Z,           Z,     Z,    F_ADDR,  32'd125, Z);
        add("edge_clr",    0,  1,  0,  0,  Z,           Z,     Z,    F_LOAD,  Z,     Z);
        add("edge_idle",   0,  0,  0,  0,  Z,           Z,     Z,    F_IDLE,  Z,     Z);
        // Zero length completes at once.
        add("zero_start",  1,  0,  0,  0,  32'd5,       32'd0, Z,    F_IDLE,  Z,     Z);
        add("zero_done",   0,  0,  0,  0,  Z,           Z,     Z,    F_DONE,  Z,     Z);
        add("zero_idle",   0,  0,  0,  0,  Z,           Z,     Z,    F_IDLE,  Z,     Z);
        // Clear after the first of 4 words, then a fresh 1-word load.
        add("clr_start",   1,  0,  0,  0,  32'd8,       32'd4, Z,    F_IDLE,  Z,     Z);
        add("clr_addr",    0,  0,  0,  0,  Z,           Z,     Z,    F_ADDR,  32'd8, Z);
        add("clr_w1",      0,  0,  0,  1,  Z,           Z,     WD,   F_LOADD, Z,     WD);
        add("clr_assert",  0,  1,  0,  0,  Z,           Z,     Z,    F_LOAD,  Z,     Z);
        add("clr_idle",    0,  0,  0,  0,  Z,           Z,     Z,    F_IDLE,  Z,     Z);
        add("clr_idle2",   0,  0,  0,  0,  Z,           Z,     Z,    F_IDLE,  Z,     Z);
        add("post_start",  1,  0,  0,  0,  32'd9,       32'd1, Z,    F_IDLE,  Z,     Z);
        add("post_addr",   0,  0,  0,  0,  Z,           Z,     Z,    F_ADDR,  32'd9, Z);
        add("post_w1",     0,  0,  0,  1,  Z,           Z,     WA,   F_LOADD, Z,     WA);
        add("post_finish", 0,  0,  0,  0,  Z,           Z,     Z,    F_FIN,   Z,     Z);
        add("post_idle",   0,  0,  0,  0,  Z,           Z,     Z,    F_IDLE,  Z,     Z);
`else
        // Autostart: 2-word load, core runs for 10 cycles.
        add("as_start",    1,  0,  0,  0,  32'd0,       32'd2, Z,    F_IDLE,  Z,     Z);
        add("as_addr",     0,  0,  0,  0,  Z,           Z,     Z,    F_ADDR,  Z,     Z);
        add("as_w1",       0,  0,  0,  1,  Z,           Z,     WA,   F_LOADD, Z,     WA);
        add("as_w2",       0,  0,  0,  1,  Z,           Z,     WB,   F_LOADD, Z,     WB);
        add("as_finish",   0,  0,  0,  0,  Z,           Z,     Z,    F_FINCS, Z,     Z);
        add("as_run_wait", 0,  0,  0,  0,  Z,           Z,     Z,    F_RUN,   Z,     Z);
        for (int i = 0; i < 10; i++)
            add("as_run_en", 0,  0,  1,  0,  Z,           Z,     Z,    F_RUN,   Z,     Z);
        add("as_en_fall",  0,  0,  0,  0,  Z,           Z,     Z,    F_RUN,   Z,     Z);
        add("as_idle",     0,  0,  0,  0,  Z,           Z,     Z,    F_IDLE,  Z,     Z);
`endif

        foreach (vq[i]) apply(vq[i]);

        // Reset asserted mid-load: all outputs drop at once and stay low.
        begin
            vec_t v;
            v.name = "rst_start"; v.start = 1'b1; v.clr = 1'b0; v.en = 1'b0; v.valid = 1'b0;
            v.base = 32'd2; v.len = 32'd3; v.data = Z; v.flags = F_IDLE; v.addr = Z; v.wdata = Z;
            apply(v);
            v.name = "rst_addr"; v.start = 1'b0; v.base = Z; v.len = Z;
            v.flags = F_ADDR; v.addr = 32'd2;
            apply(v);
            v.name = "rst_w1"; v.valid = 1'b1; v.data = WC;
            v.flags = F_LOADD; v.addr = Z; v.wdata = WC;
            apply(v);
            rst_ni = 1'b0;
            #1;
            compare("rst_async", F_IDLE, Z, Z);
            @(negedge clk_i);
            #1;
            compare("rst_held", F_IDLE, Z, Z);
            rst_ni = 1'b1;
            v.name = "rst_after"; v.valid = 1'b0; v.data = Z;
            v.flags = F_IDLE; v.wdata = Z;
            apply(v);
            v.name = "rst_reload"; v.start = 1'b1; v.base = 32'd3; v.len = 32'd2;
            apply(v);
            v.name = "rst_readdr"; v.start = 1'b0; v.base = Z; v.len = Z;
            v.flags = F_ADDR; v.addr = 32'd3;
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/inst_prog_loader.md
INST_PROG_LOADER -- requirements
Module: inst_prog_loader

Interface
REQ-001 SHALL have parameter RegAddrWidth, default 32: CSR and instruction word width.
REQ-002 SHALL have parameter InstMemDepth, default 128: instruction memory depth in words.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i input 1 is the clock, rising edge; rst_ni input 1 is the asynchronous active-low reset.
REQ-004 SHALL have clr_i input 1: synchronous clear.
REQ-005 SHALL have load_start_i input 1: single-cycle request to begin a program load.
REQ-006 SHALL have cfg_base_addr_i input RegAddrWidth: first instruction address, sampled on accepted load_start_i.
REQ-007 SHALL have cfg_len_i input RegAddrWidth: number of words to load, sampled on accepted load_start_i.
REQ-008 SHALL have data_i input RegAddrWidth, data_valid_i input 1 and data_ready_o output 1: instruction stream, valid/ready handshake.
REQ-009 SHALL have the following instruction-control outputs: inst_wr_mode_o output 1, inst_wr_addr_o output RegAddrWidth, inst_wr_addr_en_o output 1, inst_wr_data_o output RegAddrWidth, inst_wr_data_en_o output 1 and inst_pc_reset_o output 1.
REQ-010 SHALL have core_start_o output 1 (core start pulse) and core_enable_i input 1 (core running status).
REQ-011 SHALL have the following status outputs: busy_o output 1 (not IDLE), done_o output 1 (one-cycle completion pulse) and err_o output 1 (one-cycle rejection pulse).

Function
REQ-012 SHALL implement the FSM states IDLE, ADDR, LOAD and FINISH, plus RUN when the macro of REQ-027 is defined.
REQ-013 In IDLE, load_start_i SHALL latch the base and length; the next state SHALL be ADDR when 1 <= len and base+len <= InstMemDepth.
REQ-014 IDLE with load_start_i and len==0 SHALL pulse done_o in the next cycle and remain in IDLE.
REQ-015 IDLE with load_start_i and base+len > InstMemDepth SHALL pulse err_o in the next cycle and remain in IDLE; the comparison SHALL be computed at RegAddrWidth+1 bits so that it cannot wrap.
REQ-016 ADDR SHALL last exactly one cycle, driving inst_wr_mode_o=1, inst_wr_addr_en_o=1 and inst_wr_addr_o=latched base, then go to LOAD.
REQ-017 In LOAD, inst_wr_mode_o and data_ready_o SHALL be 1; inst_wr_data_en_o SHALL equal data_valid_i and inst_wr_data_o SHALL equal data_i, combinationally.
REQ-018 Each handshake (valid && ready) SHALL increment the word counter; the handshake with counter==len-1 SHALL move the FSM to FINISH, with no further ready.
REQ-019 Stalls on data_valid_i SHALL be unbounded, with the outputs held and no timeout.
REQ-020 FINISH SHALL last exactly one cycle, driving inst_wr_mode_o=0, inst_pc_reset_o=1 and done_o=1, then go to IDLE (or RUN, see REQ-027).
REQ-021 load_start_i outside IDLE SHALL be ignored.
REQ-022 Outside their active states, all strobe outputs SHALL be 0 and inst_wr_addr_o/inst_wr_data_o SHALL be 0.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 clr_i SHALL have priority over all other inputs: the next state SHALL be IDLE with the counter and latched config zeroed; no done_o or err_o SHALL be raised.

Reset
REQ-025 On rst_ni low, the FSM SHALL enter IDLE and the counter, latched base and latched length SHALL be 0.
REQ-026 All outputs SHALL be 0 during and after reset until the first accepted load; this SHALL hold for resets asserted mid-load, with the partially written memory left as-is.

Configuration
REQ-027 With INST_PROG_LOADER_AUTOSTART_EN defined:
- FINISH SHALL additionally pulse core_start_o and go to RUN.
- RUN SHALL keep busy_o=1 until core_enable_i has been observed high and then low, then return to IDLE.
- clr_i SHALL exit RUN to IDLE.
REQ-028 Without INST_PROG_LOADER_AUTOSTART_EN:
- The RUN state SHALL NOT exist.
- core_start_o SHALL be tied to 0.
- core_enable_i SHALL be unused.

Verification
REQ-029 Bench SHALL cover: base=4, len=3, words A,B,C streamed back-to-back. Required response: addr_en at cycle 1 with addr=4; data_en at cycles 2-4; FINISH at cycle 5 with pc_reset=1 and done_o=1.
REQ-030 Bench SHALL cover: len=3 with data_valid_i low for 5 cycles between the 1st and 2nd words. Required response: exactly 3 data_en pulses; done_o 1 cycle after the 3rd handshake.
REQ-031 Bench SHALL cover: base=126, len=3, InstMemDepth=128. Required response: err_o pulse; busy_o stays 0; no write strobes.
REQ-032 Bench SHALL cover: len=0. Required response: done_o pulse in the next cycle; no ADDR state; no strobes.
REQ-033 Bench SHALL cover: clr_i asserted after the 1st of 4 words. Required response: IDLE next cycle; busy_o=0; no done_o; a subsequent load succeeds.
REQ-034 Bench SHALL cover, with AUTOSTART_EN: a 2-word load, then core_enable_i high for 10 cycles. Required response: core_start_o coincides with done_o; busy_o falls the cycle after core_enable_i falls.
